// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_operand_stage
// Description : ID/EX pipeline register for the execute stage. Captures the
//               decoded instruction, turns ALUOp/funct into the 4-bit ALU
//               control code at capture time, forwards operands from EX/MEM
//               and MEM/WB, and detects load-use hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_operand_stage #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            id_valid,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [RA_W-1:0] id_rs1,
   input  logic [RA_W-1:0] id_rs2,
   input  logic [RA_W-1:0] id_rd,
   input  logic [1:0]      id_alu_op,
   input  logic [2:0]      id_funct3,
   input  logic            id_funct7_5,
   input  logic            id_alu_src,
   input  logic            id_reg_write,
   input  logic            id_mem_read,
   input  logic            id_mem_write,
   input  logic            stall,
   input  logic            flush,
   input  logic            ex_mem_reg_write,
   input  logic [RA_W-1:0] ex_mem_rd,
   input  logic [XLEN-1:0] ex_mem_result,
   input  logic            mem_wb_reg_write,
   input  logic [RA_W-1:0] mem_wb_rd,
   input  logic [XLEN-1:0] mem_wb_result,
   output logic [XLEN-1:0] first_operand,
   output logic [XLEN-1:0] second_operand,
   output logic [3:0]      ALU_Control,
   output logic [XLEN-1:0] ex_store_data,
   output logic [RA_W-1:0] ex_rd,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic            ex_valid,
   output logic            load_use_stall,
   output logic            illegal_op
);

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   logic [RA_W-1:0] ex_rs1;
   logic [RA_W-1:0] ex_rs2;
   logic [XLEN-1:0] ex_rs1_data;
   logic [XLEN-1:0] ex_rs2_data;
   logic [XLEN-1:0] ex_imm;
   logic            ex_alu_src;
   logic [3:0]      dec_ctrl;
   logic            dec_illegal;
   logic            insert_bubble;
   logic [XLEN-1:0] fwd_a;
   logic [XLEN-1:0] fwd_b;

   // Decode ALUOp/funct from the ID slot so the code is ready at capture
   always_comb begin
      dec_ctrl    = ALU_ADD;
      dec_illegal = 1'b0;
      case (id_alu_op)
         2'b00: dec_ctrl = ALU_ADD;
         2'b01: dec_ctrl = ALU_SUB;
         2'b10: begin
            case (id_funct3)
               3'b000:  dec_ctrl = id_funct7_5 ? ALU_SUB : ALU_ADD;
               3'b111:  dec_ctrl = ALU_AND;
               3'b110:  dec_ctrl = ALU_OR;
               3'b010:  dec_ctrl = ALU_SLT;
               default: dec_illegal = 1'b1;
            endcase
         end
         default: begin
            // I-type arithmetic: bit 30 belongs to the immediate, so ignore it
            case (id_funct3)
               3'b000:  dec_ctrl = ALU_ADD;
               3'b111:  dec_ctrl = ALU_AND;
               3'b110:  dec_ctrl = ALU_OR;
               3'b010:  dec_ctrl = ALU_SLT;
               default: dec_illegal = 1'b1;
            endcase
         end
      endcase
   end

   // Load in EX whose destination is read by the ID instruction (rs2 always compared)
   always_comb begin
      load_use_stall = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
                       ((ex_rd == id_rs1) || (ex_rd == id_rs2));
   end

   // Flush beats stall; a load-use bubble only goes in when not held
   always_comb begin
      insert_bubble = flush || (!stall && load_use_stall);
   end

   // ID/EX register: bubble on reset/flush/hazard, hold on stall, else capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset || insert_bubble) begin
         ex_valid     <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         ex_rd        <= '0;
         ex_rs1       <= '0;
         ex_rs2       <= '0;
         ex_rs1_data  <= '0;
         ex_rs2_data  <= '0;
         ex_imm       <= '0;
         ex_alu_src   <= 1'b0;
         ALU_Control  <= ALU_ADD;
         illegal_op   <= 1'b0;
      end else if (!stall) begin
         ex_valid     <= id_valid;
         ex_reg_write <= id_reg_write;
         ex_mem_read  <= id_mem_read;
         ex_mem_write <= id_mem_write;
         ex_rd        <= id_rd;
         ex_rs1       <= id_rs1;
         ex_rs2       <= id_rs2;
         ex_rs1_data  <= id_rs1_data;
         ex_rs2_data  <= id_rs2_data;
         ex_imm       <= id_imm;
         ex_alu_src   <= id_alu_src;
         ALU_Control  <= dec_ctrl;
         illegal_op   <= dec_illegal;
      end
   end

   // Operand forwarding: youngest producer (EX/MEM) first, x0 never forwarded
   always_comb begin
      if (ex_mem_reg_write && (ex_mem_rd != '0) && (ex_mem_rd == ex_rs1))
         fwd_a = ex_mem_result;
      else if (mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == ex_rs1))
         fwd_a = mem_wb_result;
      else
         fwd_a = ex_rs1_data;

      if (ex_mem_reg_write && (ex_mem_rd != '0) && (ex_mem_rd == ex_rs2))
         fwd_b = ex_mem_result;
      else if (mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == ex_rs2))
         fwd_b = mem_wb_result;
      else
         fwd_b = ex_rs2_data;
   end

   // ALU operand and store-data selection
   always_comb begin
      first_operand  = fwd_a;
      second_operand = ex_alu_src ? ex_imm : fwd_b;
      ex_store_data  = fwd_b;
   end

endmodule
`default_nettype wire

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register for the execute stage; its outputs drive the ALU's `first_operand`, `second_operand` and `ALU_Control` inputs directly.
- Latches decoded instruction fields on each clock and decodes ALUOp/funct into the 4-bit ALU control code.
- Contains operand forwarding from EX/MEM and MEM/WB, plus load-use hazard detection.
- Supports external stall (hold) and flush (bubble insertion).

Parameters:
- XLEN, 32, data/operand width
- RA_W, 5, register address width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  ID slot holds a real instruction
- id_rs1_data  in  XLEN  register file read port 1
- id_rs2_data  in  XLEN  register file read port 2
- id_imm  in  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  RA_W  register addresses
- id_alu_op  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type arith
- id_funct3  in  3  instruction funct3
- id_funct7_5  in  1  instruction bit 30
- id_alu_src  in  1  1 = second operand is immediate
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits
- stall  in  1  external hold
- flush  in  1  branch/exception kill
- ex_mem_reg_write  in  1, ex_mem_rd  in  RA_W, ex_mem_result  in  XLEN  EX/MEM forwarding source
- mem_wb_reg_write  in  1, mem_wb_rd  in  RA_W, mem_wb_result  in  XLEN  MEM/WB forwarding source
- first_operand  out  XLEN  ALU operand A
- second_operand  out  XLEN  ALU operand B
- ALU_Control  out  4  ALU function code
- ex_store_data  out  XLEN  forwarded rs2, for the store path
- ex_rd  out  RA_W; ex_reg_write, ex_mem_read, ex_mem_write, ex_valid  out  1 each  registered pass-through
- load_use_stall  out  1  combinational; upstream must hold PC and IF/ID
- illegal_op  out  1  registered; unsupported ALU encoding

Behaviour:
- Register update priority at posedge clk, highest first:
  - reset (asynchronous): load bubble.
  - flush: load bubble. Flush also wins over stall.
  - stall: hold all registers.
  - load_use_stall: load bubble.
  - otherwise: load the ID inputs.
- Bubble contents: ex_valid=0; reg_write/mem_read/mem_write=0; rd, rs1, rs2=0; data/imm registers=0; ALU_Control=0010; illegal_op=0.
- Reset values of outputs: first_operand=0, second_operand=0, ALU_Control=0010, ex_store_data=0, all control outputs 0. load_use_stall=0 because ex_valid=0.
- ALU_Control decode happens at capture, so it is registered with zero added latency:
  - alu_op 00 → 0010 (add).
  - alu_op 01 → 0110 (sub).
  - alu_op 10, by funct3:
    - 000 with funct7_5=0 → 0010; 000 with funct7_5=1 → 0110.
    - 111 → 0000.
    - 110 → 0001.
    - 010 → 0111.
  - alu_op 11, by funct3 (funct7_5 ignored): 000 → 0010, 111 → 0000, 110 → 0001, 010 → 0111.
  - Any other combination → 0010 with illegal_op=1. illegal_op is only meaningful while ex_valid=1.
- Forwarding is combinational on the registered ex_rs1/ex_rs2.
  - Operand A = ex_mem_result if ex_mem_reg_write, ex_mem_rd≠0 and ex_mem_rd==ex_rs1.
  - Else Operand A = mem_wb_result if mem_wb_reg_write, mem_wb_rd≠0 and mem_wb_rd==ex_rs1.
  - Else Operand A = the registered rs1 data.
  - EX/MEM has priority over MEM/WB. Register x0 is never forwarded.
  - fwd_b is resolved the same way against ex_rs2.
- first_operand = fwd_a. second_operand = ex_alu_src ? ex_imm : fwd_b. ex_store_data = fwd_b always.
- load_use_stall = ex_valid & ex_mem_read & (ex_rd≠0) & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2). The check is conservative: rs2 is compared even for I-type instructions.
- Interaction of stalls:
  - While stall=1, load_use_stall is still driven. No bubble is inserted, because the registers hold.
  - Stall and flush asserted together → bubble.
- Reset asserted mid-operation clears everything asynchronously; the first capture happens on the first edge after deassertion.

Test Plan:
- Reset, then R-type add: id_alu_op=10, funct3=000, funct7_5=0, rs1_data=5, rs2_data=7 → next cycle ALU_Control=0010, first_operand=5, second_operand=7, ex_valid=1.
- Immediate path: alu_op=11, funct3=010, alu_src=1, imm=0xFFFF_FFFC → ALU_Control=0111, second_operand=0xFFFF_FFFC. With funct7_5=1, alu_op=10, funct3=000 → ALU_Control=0110.
- Forwarding priority: ex_rs1=3, ex_mem_rd=3 (result 0xAA), mem_wb_rd=3 (result 0xBB), both reg_write=1 → first_operand=0xAA. Same setup with ex_mem_rd=0 and mem_wb_rd=0 → registered rs1 data.
- Load-use: a load to x4 is in EX, ID rs2=4 → load_use_stall=1 that cycle; next cycle ex_valid=0, ALU_Control=0010, and the dependent instruction captures once the load leaves.
- Stall holds, flush wins: stall=1 for 3 cycles → outputs unchanged; stall=1 and flush=1 → bubble. Illegal case alu_op=10, funct3=001 → illegal_op=1, ALU_Control=0010.
- Asynchronous reset asserted between edges mid-stream → all outputs reach reset values without waiting for a clock edge.
